// File: rtl/stream_arb_mux.sv
// stream_arb_mux: registered N-channel stream multiplexer with valid/ready
// handshakes. The arbiter runs round-robin, fixed-priority or forced-select,
// and a packet lock keeps the grant on one channel until its last beat is taken.
module stream_arb_mux #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Lowest set bit of v as {found, index}.
  function automatic logic [SW:0] f_first_set(input logic [N-1:0] v);
    logic [SW:0] res;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      res = v[k] ? {1'b1, SW'(k)} : res;
    end
    return res;
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SW-1:0]  r_lock_ch;
  logic [SW-1:0]  r_rr_ptr;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_out_last;
  logic [SW-1:0]  r_out_ch;

  logic           w_load;
  logic           w_xfer;
  logic           w_grant_valid;
  logic [SW-1:0]  w_grant;
  logic [W-1:0]   w_gdata;
  logic           w_glast;
  logic [N-1:0]   w_hi_mask;
  logic [SW:0]    w_rr_hi;
  logic [SW:0]    w_rr_lo;
  logic [SW:0]    w_rr;
  logic [SW:0]    w_prio;
  logic [SW:0]    w_forced;
  logic           w_forced_hit;

  // The output register can take a new beat when empty or being drained;
  // nothing is accepted while reset is held.
  assign w_load = (~r_out_valid | out_ready) & rst_n;
  assign w_xfer = w_load & w_grant_valid;

  // Round-robin: first valid channel at or above the pointer, else wrap to
  // the lowest valid channel below it.
  assign w_hi_mask = ~((N'(1) << r_rr_ptr) - N'(1));
  assign w_rr_hi   = f_first_set(in_valid & w_hi_mask);
  assign w_rr_lo   = f_first_set(in_valid);
  assign w_rr      = w_rr_hi[SW] ? w_rr_hi : w_rr_lo;
  assign w_prio    = f_first_set(in_valid);

  // Out-of-range sel shifts the one-hot off the top, so it never hits.
  assign w_forced_hit = |(in_valid & (N'(1) << sel));
  assign w_forced     = w_forced_hit ? {1'b1, sel} : '0;

  // Grant selection: locked channel only, otherwise per arbitration mode.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    case (r_state)
      ST_LOCKED: begin
        w_grant_valid = in_valid[r_lock_ch];
        w_grant       = r_lock_ch;
      end
      ST_IDLE: begin
        case (mode)
          2'd1:    {w_grant_valid, w_grant} = w_prio;
          2'd2:    {w_grant_valid, w_grant} = w_forced;
          default: {w_grant_valid, w_grant} = w_rr;
        endcase
      end
      default: begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
      end
    endcase
  end

  // Data and last marker of the granted channel.
  always_comb begin
    w_gdata = '0;
    w_glast = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_gdata = (w_grant == SW'(k)) ? in_data[k*W +: W] : w_gdata;
      w_glast = (w_grant == SW'(k)) ? in_last[k]        : w_glast;
    end
  end

  // Only the granted channel sees ready, and only when a beat can be taken.
  assign in_ready = w_xfer ? (N'(1) << w_grant) : '0;

  // Packet lock: enter on a non-last beat, leave on the locked channel's last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && !w_glast) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_xfer && w_glast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, lock channel and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_xfer && !w_glast) begin
        r_lock_ch <= w_grant;
      end
      if (w_xfer && w_glast) begin
        r_rr_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);
      end
    end
  end

  // Output beat register: load on transfer, empty when drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_last  <= w_glast;
      r_out_ch    <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux. Uses N=5 so the 3-bit sel can carry indices
// beyond the channel count, and so the round-robin wrap is not a power of two.
module tb_stream_arb_mux;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk;
  logic           rst_n;
  logic [1:0]     mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;

  stream_arb_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  int           m_ch;
  logic         m_locked;
  int           m_lock;
  int           m_rr;

  function automatic logic [W-1:0] chan_data(input int k);
    return in_data[k*W +: W];
  endfunction

  // Which channel the rules say wins right now, -1 for none.
  function automatic int m_grant();
    int k;
    if (m_locked) return in_valid[m_lock] ? m_lock : -1;
    case (mode)
      2'd1: begin
        for (int i = 0; i < N; i++) if (in_valid[i]) return i;
        return -1;
      end
      2'd2: begin
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (in_valid[k]) return k;
        end
        return -1;
      end
    endcase
  endfunction

  function automatic int exp_ready();
    int g;
    g = m_grant();
    if (g >= 0 && (!m_valid || out_ready)) return 1 << g;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_data <= '0; m_last <= 1'b0; m_ch <= 0;
      m_locked <= 1'b0; m_lock <= 0; m_rr <= 0;
    end else if (m_grant() >= 0 && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_data  <= chan_data(m_grant());
      m_last  <= in_last[m_grant()];
      m_ch    <= m_grant();
      if (in_last[m_grant()]) begin
        m_locked <= 1'b0;
        m_rr     <= (m_grant() + 1) % N;
      end else begin
        m_locked <= 1'b1;
        m_lock   <= m_grant();
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_ch", out_ch, 0);
    end else begin
      chk("model_in_ready", in_ready, exp_ready());
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("model_out_data", out_data, m_data);
        chk("model_out_last", out_last, m_last);
        chk("model_out_ch", out_ch, m_ch);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic l, input logic [W-1:0] d);
    in_valid[k]      = v;
    in_last[k]       = l;
    in_data[k*W +: W] = d;
  endtask

  int rr_seq [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n = 1'b0; mode = 2'd0; sel = '0;
    in_valid = '1; in_last = '1; in_data = '0; out_ready = 1'b1;

    // Reset with every channel valid: nothing accepted, outputs cleared.
    repeat (3) cyc();
    chk("t1_out_valid", out_valid, 0);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_out_ch", out_ch, 0);
    in_valid = '0;
    rst_n = 1'b1;
    cyc();

    // Round-robin, all valid, single-beat packets: 0,1,2,3,4,0.
    for (int k = 0; k < N; k++) set_ch(k, 1'b1, 1'b1, 8'h10 + 8'(k));
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t2_rr_ch", out_ch, rr_seq[i]);
      chk("t2_rr_data", out_data, 8'h10 + 8'(rr_seq[i]));
    end
    in_valid = '0;
    cyc();

    // Move the pointer to N-1 with a priority-mode packet on ch3.
    mode = 2'd1;
    set_ch(3, 1'b1, 1'b1, 8'h33);
    cyc();
    chk("t6_prep_ch", out_ch, 3);
    in_valid = '0;
    // Wrap: ch4 and ch0 valid -> 4, 0, then 4 again.
    mode = 2'd0;
    set_ch(4, 1'b1, 1'b1, 8'h44);
    set_ch(0, 1'b1, 1'b1, 8'h40);
    cyc(); chk("t6_wrap_ch_a", out_ch, 4);
    cyc(); chk("t6_wrap_ch_b", out_ch, 0);
    cyc(); chk("t6_wrap_ch_c", out_ch, 4);
    in_valid = '0;
    cyc();

    // Backpressure: hold out_ready low for four cycles with a beat held.
    set_ch(1, 1'b1, 1'b1, 8'h21);
    set_ch(3, 1'b1, 1'b1, 8'h23);
    out_ready = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_stall_ready", in_ready, 0);
      chk("t4_stall_data", out_data, 8'h21);
      chk("t4_stall_valid", out_valid, 1);
      cyc();
    end
    out_ready = 1'b1;
    cyc(); chk("t4_resume_a", out_data, 8'h23);
    cyc(); chk("t4_resume_b", out_data, 8'h21);
    in_valid = '0;
    cyc();
    cyc();

    // Packet lock in priority mode: ch2 3-beat packet holds off ch0.
    mode = 2'd1;
    set_ch(2, 1'b1, 1'b0, 8'hA0);
    cyc();
    chk("t3_beat1_ch", out_ch, 2);
    set_ch(0, 1'b1, 1'b1, 8'h55);
    set_ch(2, 1'b1, 1'b0, 8'hA1);
    settle();
    chk("t3_lock_ready", in_ready, 5'b00100);
    cyc();
    chk("t3_beat2_data", out_data, 8'hA1);
    set_ch(2, 1'b0, 1'b0, 8'hA1);
    settle();
    chk("t3_bubble_ready", in_ready, 5'b00000);
    cyc();
    chk("t3_bubble_valid", out_valid, 0);
    set_ch(2, 1'b1, 1'b1, 8'hA2);
    settle();
    chk("t3_beat3_ready", in_ready, 5'b00100);
    cyc();
    chk("t3_beat3_ch", out_ch, 2);
    chk("t3_beat3_last", out_last, 1);
    set_ch(2, 1'b0, 1'b0, 8'h00);
    cyc();
    chk("t3_after_ch", out_ch, 0);
    chk("t3_after_data", out_data, 8'h55);
    in_valid = '0;
    cyc();

    // Forced select: sel=1 wins over lower ch0; out-of-range sel grants nothing.
    mode = 2'd2;
    sel = 3'd1;
    set_ch(1, 1'b1, 1'b1, 8'hA5);
    set_ch(0, 1'b1, 1'b1, 8'h50);
    cyc();
    chk("t5_forced_data", out_data, 8'hA5);
    chk("t5_forced_ch", out_ch, 1);
    sel = 3'd5;
    settle();
    chk("t5_sel5_ready", in_ready, 0);
    cyc();
    chk("t5_sel5_valid", out_valid, 0);
    sel = 3'd7;
    set_ch(4, 1'b1, 1'b1, 8'h54);
    settle();
    chk("t5_sel7_ready", in_ready, 0);
    sel = 3'd4;
    settle();
    chk("t5_sel4_ready", in_ready, 5'b10000);
    cyc();
    chk("t5_sel4_data", out_data, 8'h54);
    in_valid = '0;
    mode = 2'd0;
    cyc();

    // Reset mid-packet: lock released, held beat dropped, pointer back to 0.
    set_ch(2, 1'b1, 1'b0, 8'hC0);
    cyc();
    chk("t7_start_ch", out_ch, 2);
    set_ch(2, 1'b1, 1'b0, 8'hC2);
    set_ch(1, 1'b1, 1'b1, 8'hC1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_valid", out_valid, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t7_unlocked_ch", out_ch, 1);
    chk("t7_unlocked_data", out_data, 8'hC1);
    in_valid = '0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
